// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode encodings, controller states and status-flag bundle.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start_i.
// last_o is high during the final iteration; product_o is valid the cycle after.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      cnt_d    = CW'(WIDTH);
      acc_d    = {WIDTH{1'b0}};
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (cnt_q != {CW{1'b0}}) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign last_o    = (cnt_q == CW'(1));
  assign product_o = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and registered result/flags.
// Define SEQ_ALU_MUL_EN to build in the iterative multiplier (opcode 1010).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] alu_res_s;
  flags_t           alu_flags_s;
  flags_t           mul_flags_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [SW-1:0]    shamt_s;
  logic             xfer_s, is_mul_s, fsm_idle_s, mul_load_s;
  logic [WIDTH-1:0] mul_prod_s;

  assign shamt_s  = op2[SW-1:0];
  assign sum_s    = {1'b0, op1} + {1'b0, op2};
  assign diff_s   = {1'b0, op1} - {1'b0, op2};
  assign in_ready = fsm_idle_s && (!out_valid_q || out_ready);
  assign xfer_s   = in_valid && in_ready;

  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_flags_s = flags_t'(5'b00000);
    case (alu_op)
      OP_ADD: begin
        alu_res_s         = sum_s[WIDTH-1:0];
        alu_flags_s.carry = sum_s[WIDTH];
        alu_flags_s.ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s         = diff_s[WIDTH-1:0];
        alu_flags_s.carry = diff_s[WIDTH];
        alu_flags_s.ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_s[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND:  alu_res_s = op1 & op2;
      OP_OR:   alu_res_s = op1 | op2;
      OP_XOR:  alu_res_s = op1 ^ op2;
      OP_SLL:  alu_res_s = op1 << shamt_s;
      OP_SRL:  alu_res_s = op1 >> shamt_s;
      OP_SRA:  alu_res_s = $signed(op1) >>> shamt_s;
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
`ifdef SEQ_ALU_MUL_EN
      // Product is delivered later by the multiplier; nothing is loaded from here.
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
`endif
      default: alu_flags_s.illegal = 1'b1;
    endcase
    alu_flags_s.zero = (alu_res_s == {WIDTH{1'b0}});
    alu_flags_s.neg  = alu_res_s[WIDTH-1];
  end

`ifdef SEQ_ALU_MUL_EN
  state_e state_q, state_d;
  logic   mul_start_s, mul_last_s;

  assign is_mul_s   = (alu_op == OP_MUL);
  assign fsm_idle_s = (state_q == ST_IDLE);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_s),
    .a_i       (op1),
    .b_i       (op2),
    .last_o    (mul_last_s),
    .product_o (mul_prod_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mul_start_s = 1'b0;
    mul_load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s && is_mul_s) begin
          state_d     = ST_MUL;
          mul_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (!out_valid_q || out_ready) begin
          mul_load_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
`else
  assign is_mul_s   = 1'b0;
  assign fsm_idle_s = 1'b1;
  assign mul_load_s = 1'b0;
  assign mul_prod_s = {WIDTH{1'b0}};
`endif

  always_comb begin
    mul_flags_s      = flags_t'(5'b00000);
    mul_flags_s.zero = (mul_prod_s == {WIDTH{1'b0}});
    mul_flags_s.neg  = mul_prod_s[WIDTH-1];
  end

  // Result registers: load on accepted op or finished multiply, otherwise hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= flags_t'(5'b00000);
      out_valid_q <= 1'b0;
    end else if (xfer_s && !is_mul_s) begin
      result_q    <= alu_res_s;
      flags_q     <= alu_flags_s;
      out_valid_q <= 1'b1;
    end else if (mul_load_s) begin
      result_q    <= mul_prod_s;
      flags_q     <= mul_flags_s;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign zero_flag  = flags_q.zero;
  assign neg_flag   = flags_q.neg;
  assign carry_flag = flags_q.carry;
  assign ovf_flag   = flags_q.ovf;
  assign illegal_op = flags_q.illegal;

endmodule
